// File: rtl/d5m_capture.sv
// -----------------------------------------------------------------------------
// d5m_capture
//
// Capture engine for the D5M camera sensor bus. The raw bus (pixel data,
// FVAL, LVAL) is registered once, framed into a pixel stream carrying
// column/row coordinates plus start-of-frame / start-of-line flags, and
// buffered in a show-ahead FIFO with a ready/valid output.
//
// Capture is armed by a start pulse. It can grab a single frame, or keep
// re-arming after every frame until a stop pulse arrives. Completed frames
// are counted. A sticky overflow flag records any pixel dropped because the
// FIFO was full.
//
// Optional feature macro: D5M_CAPTURE_CROP_EN
//   defined   : crop_x0/x1/y0/y1 ports exist. Only pixels inside the
//               inclusive window are accepted, and coordinates are reported
//               relative to the window origin.
//   undefined : no crop ports. Every pixel of the frame is accepted, and the
//               raw coordinates are reported.
//
// Ports
//   clk, rst             system clock, synchronous active-high reset
//   d5m_d/fval/lval      sensor bus, already in the clk domain
//   start, stop, clear   one-cycle control pulses
//   continuous           capture mode, sampled when start is accepted
//   crop_*               inclusive crop window (macro builds only)
//   out_data/x/y/sof/sol FIFO head fields, zero while out_valid is low
//   out_valid/out_ready  output handshake
//   busy                 capture state machine not idle
//   frame_count          completed frames, wraps
//   overflow             sticky pixel-drop flag
// -----------------------------------------------------------------------------
module d5m_capture #(
  parameter int DATA_W     = 12,
  parameter int X_W        = 12,
  parameter int Y_W        = 11,
  parameter int FIFO_DEPTH = 16,
  parameter int FCNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d5m_d,
  input  logic              d5m_fval,
  input  logic              d5m_lval,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic              clear,
`ifdef D5M_CAPTURE_CROP_EN
  input  logic [X_W-1:0]    crop_x0,
  input  logic [X_W-1:0]    crop_x1,
  input  logic [Y_W-1:0]    crop_y0,
  input  logic [Y_W-1:0]    crop_y1,
`endif
  output logic [DATA_W-1:0] out_data,
  output logic [X_W-1:0]    out_x,
  output logic [Y_W-1:0]    out_y,
  output logic              out_sof,
  output logic              out_sol,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [FCNT_W-1:0] frame_count,
  output logic              overflow
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = DATA_W + X_W + Y_W + 2;

  typedef enum logic [1:0] {IDLE, ARM, WAIT_SOF, CAPTURE} state_t;

  // ---------------------------------------------------------------------------
  // Stage 1: register the sensor bus. Edge detection uses these copies.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] d_reg;
  logic              fval_reg, lval_reg, fval_prev_reg, lval_prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_reg         <= '0;
      fval_reg      <= 1'b0;
      lval_reg      <= 1'b0;
      fval_prev_reg <= 1'b0;
      lval_prev_reg <= 1'b0;
    end else begin
      d_reg         <= d5m_d;
      fval_reg      <= d5m_fval;
      lval_reg      <= d5m_lval;
      fval_prev_reg <= fval_reg;
      lval_prev_reg <= lval_reg;
    end
  end

  logic fval_rise, fval_fall, lval_fall, pix_in;
  assign fval_rise = fval_reg & ~fval_prev_reg;
  assign fval_fall = ~fval_reg & fval_prev_reg;
  assign lval_fall = ~lval_reg & lval_prev_reg;
  assign pix_in    = fval_reg & lval_reg;

  // ---------------------------------------------------------------------------
  // Coordinate counters. x_reg/y_reg hold the coordinates of the pixel that
  // is currently in stage 1. Both saturate instead of wrapping.
  // ---------------------------------------------------------------------------
  logic [X_W-1:0] x_reg;
  logic [Y_W-1:0] y_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg <= '0;
      y_reg <= '0;
    end else begin
      if (lval_fall)
        x_reg <= '0;
      else if (pix_in && (x_reg != '1))
        x_reg <= x_reg + 1'b1;

      if (fval_rise)
        y_reg <= '0;
      else if (lval_fall && (y_reg != '1))
        y_reg <= y_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture state machine
  // ---------------------------------------------------------------------------
  state_t state_reg, state_next;
  logic   frame_done;
  logic   mode_cont_reg;
  logic   stop_pending_reg;

  always_comb begin
    state_next = state_reg;
    frame_done = 1'b0;
    case (state_reg)
      IDLE: begin
        // A coincident stop cancels the start.
        if (start && !stop)
          state_next = ARM;
      end
      ARM: begin
        // Wait out any frame already in progress.
        if (stop)
          state_next = IDLE;
        else if (!fval_reg)
          state_next = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (stop)
          state_next = IDLE;
        else if (fval_rise)
          state_next = CAPTURE;
      end
      CAPTURE: begin
        if (fval_fall) begin
          frame_done = 1'b1;
          // A stop arriving on the very last cycle still ends the run.
          state_next = (mode_cont_reg && !stop_pending_reg && !stop) ? WAIT_SOF : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      mode_cont_reg    <= 1'b0;
      stop_pending_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == IDLE) && start && !stop)
        mode_cont_reg <= continuous;
      // Only meaningful while capturing; naturally clears on frame end.
      stop_pending_reg <= (state_reg == CAPTURE) && (stop_pending_reg || stop) && !frame_done;
    end
  end

  assign busy = (state_reg != IDLE);

  // ---------------------------------------------------------------------------
  // Crop window
  // ---------------------------------------------------------------------------
  logic           win_ok;
  logic [X_W-1:0] rel_x;
  logic [Y_W-1:0] rel_y;

`ifdef D5M_CAPTURE_CROP_EN
  logic [X_W-1:0] cx0_reg, cx1_reg;
  logic [Y_W-1:0] cy0_reg, cy1_reg;

  // The window is frozen at the start of each frame so that a mid-frame
  // change of the crop inputs cannot tear the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      cx0_reg <= '0;
      cx1_reg <= '0;
      cy0_reg <= '0;
      cy1_reg <= '0;
    end else if ((state_reg == WAIT_SOF) && fval_rise) begin
      cx0_reg <= crop_x0;
      cx1_reg <= crop_x1;
      cy0_reg <= crop_y0;
      cy1_reg <= crop_y1;
    end
  end

  // An inverted window fails one of the compares and accepts nothing.
  assign win_ok = (x_reg >= cx0_reg) && (x_reg <= cx1_reg) &&
                  (y_reg >= cy0_reg) && (y_reg <= cy1_reg);
  assign rel_x  = x_reg - cx0_reg;
  assign rel_y  = y_reg - cy0_reg;
`else
  assign win_ok = 1'b1;
  assign rel_x  = x_reg;
  assign rel_y  = y_reg;
`endif

  // ---------------------------------------------------------------------------
  // Pixel acceptance and frame/line marker flags
  // ---------------------------------------------------------------------------
  logic accept;
  logic sof_pending_reg, sol_pending_reg;

  assign accept = (state_reg == CAPTURE) && pix_in && win_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      sof_pending_reg <= 1'b0;
      sol_pending_reg <= 1'b0;
    end else begin
      if ((state_next == CAPTURE) && (state_reg != CAPTURE))
        sof_pending_reg <= 1'b1;
      else if (accept)
        sof_pending_reg <= 1'b0;

      // Re-armed at each line end, so a row that lies entirely outside the
      // window does not consume the marker of the next row.
      if (accept)
        sol_pending_reg <= 1'b0;
      else if (lval_fall || (state_reg != CAPTURE))
        sol_pending_reg <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Show-ahead output FIFO
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               full, pop, push_ok, drop;

  assign full      = (count_reg == CNT_W'(FIFO_DEPTH));
  assign out_valid = (count_reg != '0);
  assign pop       = out_valid & out_ready;
  // When full, a same-cycle pop frees the slot being written.
  assign push_ok   = accept && (!full || pop);
  assign drop      = accept && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr_reg] <= {sof_pending_reg, sol_pending_reg, rel_y, rel_x, d_reg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Head fields are forced to zero while empty so that nothing stale from
  // the storage array is ever visible.
  logic [DATA_W-1:0] head_d;
  logic [X_W-1:0]    head_x;
  logic [Y_W-1:0]    head_y;
  logic              head_sof, head_sol;

  assign {head_sof, head_sol, head_y, head_x, head_d} = mem[rd_ptr_reg];

  assign out_data = out_valid ? head_d   : '0;
  assign out_x    = out_valid ? head_x   : '0;
  assign out_y    = out_valid ? head_y   : '0;
  assign out_sof  = out_valid ? head_sof : 1'b0;
  assign out_sol  = out_valid ? head_sol : 1'b0;

  // ---------------------------------------------------------------------------
  // Status: frame counter and sticky overflow
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (clear)
        frame_count <= frame_done ? FCNT_W'(1) : '0;
      else if (frame_done)
        frame_count <= frame_count + 1'b1;

      // A drop in the same cycle as clear is a fresh event and is kept.
      if (drop)
        overflow <= 1'b1;
      else if (clear)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_d5m_capture.sv
`timescale 1ns/1ps
module tb_d5m_capture;

  localparam int DATA_W     = 12;
  localparam int X_W        = 12;
  localparam int Y_W        = 11;
  localparam int FIFO_DEPTH = 16;
  localparam int FCNT_W     = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] d5m_d = '0;
  logic              d5m_fval = 1'b0;
  logic              d5m_lval = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              continuous = 1'b0;
  logic              clear = 1'b0;
`ifdef D5M_CAPTURE_CROP_EN
  logic [X_W-1:0]    crop_x0 = '0;
  logic [X_W-1:0]    crop_x1 = '1;
  logic [Y_W-1:0]    crop_y0 = '0;
  logic [Y_W-1:0]    crop_y1 = '1;
`endif
  logic [DATA_W-1:0] out_data;
  logic [X_W-1:0]    out_x;
  logic [Y_W-1:0]    out_y;
  logic              out_sof, out_sol, out_valid;
  logic              out_ready = 1'b0;
  logic              busy;
  logic [FCNT_W-1:0] frame_count;
  logic              overflow;

  always #5 clk = ~clk;

  d5m_capture #(
    .DATA_W(DATA_W), .X_W(X_W), .Y_W(Y_W), .FIFO_DEPTH(FIFO_DEPTH), .FCNT_W(FCNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .d5m_d(d5m_d), .d5m_fval(d5m_fval), .d5m_lval(d5m_lval),
    .start(start), .stop(stop), .continuous(continuous), .clear(clear),
`ifdef D5M_CAPTURE_CROP_EN
    .crop_x0(crop_x0), .crop_x1(crop_x1), .crop_y0(crop_y0), .crop_y1(crop_y1),
`endif
    .out_data(out_data), .out_x(out_x), .out_y(out_y),
    .out_sof(out_sof), .out_sol(out_sol),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .frame_count(frame_count), .overflow(overflow)
  );

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic              sof;
    logic              sol;
  } pix_t;

  pix_t              exp_q[$];
  logic [DATA_W-1:0] frame_vals[$];
  int checks = 0;
  int failures = 0;
  bit cons_en = 1'b1;
  int ready_pct = 100;
  int cx0 = 0, cx1 = (1 << X_W) - 1, cy0 = 0, cy1 = (1 << Y_W) - 1;
  pix_t mon_got, mon_exp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Consumer: picks out_ready each cycle and scores every handshake against
  // the expected pixel queue.
  always @(negedge clk) begin
    if (!cons_en) out_ready = 1'b0;
    else          out_ready = ($urandom_range(99) < ready_pct);
    if (cons_en && out_ready && out_valid) begin
      mon_got = {out_data, out_x, out_y, out_sof, out_sol};
      $display("pix d=%0d x=%0d y=%0d sof=%0b sol=%0b", out_data, out_x, out_y, out_sof, out_sol);
      if (exp_q.size() == 0) begin
        check("extra_pixel", 64'(mon_got), 64'bx);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pixel", 64'(mon_got), 64'(mon_exp));
      end
    end
  end

  // Reference model: which pixels of a w x h frame come out, and how tagged.
  task automatic model_push(input int w, input int h);
    pix_t p;
    bit first = 1'b1;
    for (int r = 0; r < h; r++) begin
      bit row_first = 1'b1;
      for (int c = 0; c < w; c++) begin
        if (c >= cx0 && c <= cx1 && r >= cy0 && r <= cy1) begin
          p.d = frame_vals[r*w + c];
          p.x = X_W'(c - cx0);
          p.y = Y_W'(r - cy0);
          p.sof = first;
          p.sol = row_first;
          first = 1'b0;
          row_first = 1'b0;
          exp_q.push_back(p);
        end
      end
    end
  endtask

  // Drives one sensor frame. start/stop/rst are pulsed on the first pixel of
  // the named row (-1 = never).
  task automatic send_frame(input int w, input int h, input bit capture, input bit seq,
                            input int start_row, input int stop_row, input int rst_row);
    frame_vals.delete();
    for (int i = 0; i < w*h; i++)
      frame_vals.push_back(seq ? DATA_W'(i + 1) : DATA_W'($urandom));
    if (capture) model_push(w, h);
    @(negedge clk);
    d5m_fval = 1'b1;
    d5m_lval = 1'b0;
    @(negedge clk);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        @(negedge clk);
        d5m_lval = 1'b1;
        d5m_d    = frame_vals[r*w + c];
        start    = (c == 0 && r == start_row);
        stop     = (c == 0 && r == stop_row);
        rst      = (c == 0 && r == rst_row);
        if (c == 1 && r == rst_row) begin
          check("rst_valid", 64'(out_valid), 64'd0);
          check("rst_busy", 64'(busy), 64'd0);
          check("rst_fcount", 64'(frame_count), 64'd0);
        end
      end
      @(negedge clk);
      d5m_lval = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
      rst   = 1'b0;
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end
    @(negedge clk);
    d5m_fval = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // 0 start, 1 stop, 2 clear, 3 start+stop together
  task automatic pulse(input int which);
    @(negedge clk);
    case (which)
      0: start = 1'b1;
      1: stop  = 1'b1;
      2: clear = 1'b1;
      default: begin start = 1'b1; stop = 1'b1; end
    endcase
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    clear = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_missing"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_empty"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int n, w, h, stop_row, exp_fc;
    pix_t p;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    check("reset_fcount", 64'(frame_count), 64'd0);
    check("reset_head", 64'({out_data, out_x, out_y, out_sof, out_sol}), 64'd0);

    // Single shot, 4x3 frame with values 1..12
    continuous = 1'b0;
    pulse(0);
    check("busy_rise", 64'(busy), 64'd1);
    send_frame(4, 3, 1'b1, 1'b1, -1, -1, -1);
    wait_drain("single");
    check("single_fcount", 64'(frame_count), 64'd1);
    check("single_idle", 64'(busy), 64'd0);
    send_frame(4, 3, 1'b0, 1'b0, -1, -1, -1);
    check("idle_no_pixels", 64'(out_valid), 64'd0);
    check("idle_fcount", 64'(frame_count), 64'd1);

    // start+stop together in IDLE, then stop while waiting for a frame
    pulse(3);
    check("start_stop_idle", 64'(busy), 64'd0);
    pulse(0);
    repeat (3) @(negedge clk);
    check("armed_busy", 64'(busy), 64'd1);
    pulse(1);
    check("stop_wait_sof", 64'(busy), 64'd0);
    send_frame(3, 2, 1'b0, 1'b0, -1, -1, -1);
    check("stopped_no_pixels", 64'(out_valid), 64'd0);

    // Start mid-frame: that frame is skipped, the next one captured
    pulse(2);
    check("clear_fcount", 64'(frame_count), 64'd0);
    send_frame(4, 3, 1'b0, 1'b0, 1, -1, -1);
    send_frame(4, 3, 1'b1, 1'b0, -1, -1, -1);
    wait_drain("partial");
    check("partial_fcount", 64'(frame_count), 64'd1);
    check("partial_idle", 64'(busy), 64'd0);

`ifdef D5M_CAPTURE_CROP_EN
    // Crop window x 1..2, y 1..1
    cx0 = 1; cx1 = 2; cy0 = 1; cy1 = 1;
    crop_x0 = 1; crop_x1 = 2; crop_y0 = 1; crop_y1 = 1;
    pulse(2);
    pulse(0);
    send_frame(4, 3, 1'b1, 1'b1, -1, -1, -1);
    wait_drain("crop");
    check("crop_fcount", 64'(frame_count), 64'd1);
    cx0 = 0; cx1 = (1 << X_W) - 1; cy0 = 0; cy1 = (1 << Y_W) - 1;
    crop_x0 = '0; crop_x1 = '1; crop_y0 = '0; crop_y1 = '1;
`endif

    // Continuous runs with random frames, stalls, and a stop in the last frame
    pulse(2);
    exp_fc = 0;
    ready_pct = 70;
    for (int round = 0; round < 3; round++) begin
      n = (round == 0) ? 3 : int'($urandom_range(4, 2));
      continuous = 1'b1;
      pulse(0);
      for (int k = 0; k < n; k++) begin
        w = $urandom_range(5, 2);
        h = $urandom_range(3, 1);
        stop_row = (k == n - 1) ? int'($urandom_range(h - 1, 0)) : -1;
        send_frame(w, h, 1'b1, 1'b0, -1, stop_row, -1);
        wait_drain("cont");
        exp_fc++;
        check("cont_fcount", 64'(frame_count), 64'(exp_fc));
      end
      check("cont_stopped", 64'(busy), 64'd0);
      send_frame(3, 2, 1'b0, 1'b0, -1, -1, -1);
      check("cont_no_extra", 64'(out_valid), 64'd0);
    end
    ready_pct = 100;
    check("cont_overflow", 64'(overflow), 64'd0);

    // Reset in the middle of a captured frame
    cons_en = 1'b0;
    continuous = 1'b1;
    pulse(0);
    send_frame(6, 2, 1'b0, 1'b0, -1, -1, 1);
    check("post_rst_valid", 64'(out_valid), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_fcount", 64'(frame_count), 64'd0);

    // Backpressure: 32-pixel line into a 16-entry FIFO with no consumer
    continuous = 1'b0;
    pulse(0);
    send_frame(32, 1, 1'b0, 1'b0, -1, -1, -1);
    check("bp_overflow", 64'(overflow), 64'd1);
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_head", 64'(out_data), 64'(frame_vals[0]));
    check("bp_fcount", 64'(frame_count), 64'd1);
    pulse(2);
    check("bp_clear_overflow", 64'(overflow), 64'd0);
    check("bp_clear_fcount", 64'(frame_count), 64'd0);
    check("bp_head_kept", 64'(out_data), 64'(frame_vals[0]));
    for (int c = 0; c < FIFO_DEPTH; c++) begin
      p.d = frame_vals[c];
      p.x = X_W'(c);
      p.y = '0;
      p.sof = (c == 0);
      p.sol = (c == 0);
      exp_q.push_back(p);
    end
    cons_en = 1'b1;
    wait_drain("bp");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/d5m_capture.md
# d5m_capture

Parametrised D5M sensor capture engine, the successor to the hand-wired D5M camera top level. It samples the raw sensor bus (data, FVAL, LVAL) and frames it into a pixel stream tagged with line and frame coordinates. The stream passes through an optional crop window and a show-ahead output FIFO with ready/valid handshake. It sits between the GPIO_1 pin mapping and the downstream RAW2GREY / SDRAM writer path, and adds single-shot and continuous capture modes, frame counting and overflow detection.

## Interface
- DATA_W, 12, sensor pixel width
- X_W, 12, column counter width
- Y_W, 11, row counter width
- FIFO_DEPTH, 16, output FIFO entries (power of two, ≥4)
- FCNT_W, 32, frame counter width
---
- clk  in  1  system clock; sensor bus already in this domain
- rst  in  1  synchronous, active-high reset
- d5m_d  in  DATA_W  sensor pixel data
- d5m_fval  in  1  frame valid
- d5m_lval  in  1  line valid
- start  in  1  one-cycle pulse: arm capture
- stop  in  1  one-cycle pulse: end capture after current frame
- continuous  in  1  1 = re-arm after each frame, 0 = single frame; sampled on start
- clear  in  1  one-cycle pulse: clear overflow and frame_count
- crop_x0, crop_x1  in  X_W  inclusive column window (macro only)
- crop_y0, crop_y1  in  Y_W  inclusive row window (macro only)
- out_data  out  DATA_W  pixel
- out_x  out  X_W  column relative to window origin
- out_y  out  Y_W  row relative to window origin
- out_sof  out  1  first accepted pixel of frame
- out_sol  out  1  first accepted pixel of line
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head
- busy  out  1  state ≠ IDLE
- frame_count  out  FCNT_W  completed frames
- overflow  out  1  sticky: pixel dropped on full FIFO

## Operation
- Stage 1 registers d5m_d, fval and lval on every clk. All edge detection uses the registered copies.
- States:
  - IDLE: start → ARM; mode latched from continuous.
  - ARM: wait for fval = 0 so partial frames are discarded; then → WAIT_SOF.
  - WAIT_SOF: fval rising edge → CAPTURE; crop registers latched on this edge.
  - CAPTURE: fval falling edge → frame_count += 1. Then → WAIT_SOF if continuous mode and no stop is pending; otherwise → IDLE.
- stop in ARM or WAIT_SOF → IDLE next cycle. stop in CAPTURE sets stop_pending, and the current frame completes. stop in IDLE has no effect.
- start while busy is ignored. If start and stop arrive in the same cycle in IDLE, the block stays in IDLE.
- Counters:
  - x increments per cycle with fval & lval, and clears on the lval falling edge.
  - y increments on the lval falling edge and clears on the fval rising edge.
  - Both saturate at their all-ones value and never wrap.
- A pixel is accepted when state = CAPTURE, fval & lval, and the crop window matches (x0 ≤ x ≤ x1, y0 ≤ y ≤ y1).
- out_x = x − crop_x0 and out_y = y − crop_y0. A window with x0 > x1 or y0 > y1 accepts nothing.
- out_sof marks the first accepted pixel after entering CAPTURE. out_sol marks the first accepted pixel in each row.
- FIFO:
  - Pop when out_valid & out_ready.
  - Push when full and no pop: pixel dropped, overflow set.
  - Push when full with a simultaneous pop: push accepted, count unchanged.
- clear zeroes frame_count and overflow. If clear coincides with a frame completion, frame_count = 1.
- frame_count wraps modulo 2^FCNT_W.

## Timing
- Reset values: state IDLE; FIFO empty; out_valid, out_sof, out_sol, busy and overflow = 0; frame_count = 0; out_data/out_x/out_y = 0.
- Latency: a pixel sampled at edge k is written to the FIFO at edge k+1. out_valid is high after edge k+1 if the FIFO was empty.
- out_valid is combinational from the FIFO count. Head fields stay stable while out_valid & !out_ready.
- busy rises the cycle after start and falls the cycle after the transition to IDLE.
- Reset mid-frame discards all FIFO content; no partial frame is counted.

## Configuration
- D5M_CAPTURE_CROP_EN defined: crop ports exist and the window applies as above.
- D5M_CAPTURE_CROP_EN undefined: crop ports are absent, every pixel in the frame is accepted, and out_x/out_y equal the raw x/y.

## Test plan
- Single shot: continuous = 0, start, one 4×3 frame (values 1..12), out_ready = 1 → 12 pixels with x 0–3, y 0–2; out_sof on pixel 1; out_sol on pixels 1, 5, 9; frame_count = 1; back to IDLE.
- Partial frame: start asserted mid-frame → that frame is skipped and the next full frame is captured; frame_count = 1.
- Crop: window x 1–2, y 1–1 on a 4×3 frame → exactly 2 pixels (values 6, 7), out_x 0–1, out_y 0, both flagged sof/sol on the first.
- Backpressure: out_ready = 0 over a 32-pixel line with FIFO_DEPTH = 16 → 16 stored, overflow = 1; clear → overflow = 0; head still equals the first pixel.
- Continuous then stop: 3 frames captured; stop issued mid-frame 3 → frame 3 completes, frame_count = 3, state IDLE, no frame-4 pixels.
- Reset mid-CAPTURE: rst for 1 cycle → out_valid = 0, busy = 0, frame_count = 0 on the next cycle.
